// File: rtl/segment_scan_decoder.sv
// segment_scan_decoder: receive side of the multiplexed 7-segment scan bus.
// Samples anode/cathode lines and rebuilds four hex digits. It emits a one-cycle
// frame strobe once every digit slot has been captured since the last frame.
// Latency: a capture is taken on the edge where the settle counter reaches SETTLE.
//          frame_valid is high for the cycle that follows the completing capture.
// Backpressure: none. This is a passive observer, and the outputs hold until the next frame.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   an_in[3:0]        : active-low anodes; a single low bit k selects digit k
//   seg_in[6:0]       : active-low cathodes {g,f,e,d,c,b,a}
//   digits[15:0]      : last complete frame, digit k in [4k+3:4k]
//   blank_mask[3:0]   : digit k was dark (all segments off) in the last frame
//   frame_valid       : one-cycle strobe when digits/blank_mask update
//   glyph_error       : sticky flag for an unrecognised segment pattern
module segment_scan_decoder #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  an_in,
  input  logic [6:0]  seg_in,
  output logic [15:0] digits,
  output logic [3:0]  blank_mask,
  output logic        frame_valid,
  output logic        glyph_error
);

  localparam logic [CNT_W-1:0] SETTLE_C    = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_M1_C = CNT_W'(SETTLE - 1);

  // Registered state
  logic [3:0]       prev_an_q,      prev_an_d;
  logic [6:0]       prev_seg_q,     prev_seg_d;
  logic [CNT_W-1:0] cnt_q,          cnt_d;
  logic [15:0]      shadow_q,       shadow_d;
  logic [3:0]       shadow_blank_q, shadow_blank_d;
  logic [3:0]       mask_q,         mask_d;
  logic [15:0]      digits_q,       digits_d;
  logic [3:0]       blank_q,        blank_d;
  logic             fv_q,           fv_d;
  logic             err_q,          err_d;

  // Combinational helpers
  logic       sel_vld;
  logic [1:0] sel_idx;
  logic       stable;
  logic       capture;
  logic       glyph_hit;
  logic       glyph_blank;
  logic [3:0] glyph_val;
  logic [3:0] mask_set;

  // Exactly one low anode qualifies a slot. Idle and overlapping selects
  // (ghosting during anode changeover) are simply ignored.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 2'd0;
    case (an_in)
      4'b1110: begin sel_vld = 1'b1; sel_idx = 2'd0; end
      4'b1101: begin sel_vld = 1'b1; sel_idx = 2'd1; end
      4'b1011: begin sel_vld = 1'b1; sel_idx = 2'd2; end
      4'b0111: begin sel_vld = 1'b1; sel_idx = 2'd3; end
      default: begin sel_vld = 1'b0; sel_idx = 2'd0; end
    endcase
  end

  // Segment pattern to hex value. Patterns are active-low {g,f,e,d,c,b,a}.
  always_comb begin
    glyph_hit   = 1'b1;
    glyph_blank = 1'b0;
    glyph_val   = 4'h0;
    case (seg_in)
      7'b1000000: glyph_val = 4'h0;
      7'b1111001: glyph_val = 4'h1;
      7'b0100100: glyph_val = 4'h2;
      7'b0110000: glyph_val = 4'h3;
      7'b0011001: glyph_val = 4'h4;
      7'b0010010: glyph_val = 4'h5;
      7'b0000010: glyph_val = 4'h6;
      7'b1111000: glyph_val = 4'h7;
      7'b0000000: glyph_val = 4'h8;
      7'b0010000: glyph_val = 4'h9;
      7'b0001000: glyph_val = 4'hA;
      7'b0000011: glyph_val = 4'hB;
      7'b1000110: glyph_val = 4'hC;
      7'b0100001: glyph_val = 4'hD;
      7'b0000110: glyph_val = 4'hE;
      7'b0001110: glyph_val = 4'hF;
      7'b1111111: begin
        glyph_hit   = 1'b0;
        glyph_blank = 1'b1;
      end
      default: glyph_hit = 1'b0;
    endcase
  end

  // Settle counter. It counts edges on which the bus matched the previous sample.
  // It saturates so that only the SETTLE-1 -> SETTLE step produces a capture,
  // which gives one capture per dwell however long the digit is held.
  always_comb begin
    stable  = (an_in == prev_an_q) && (seg_in == prev_seg_q);
    capture = sel_vld && stable && (cnt_q == SETTLE_M1_C);
    cnt_d   = '0;
    if (sel_vld && stable) begin
      cnt_d = (cnt_q == SETTLE_C) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // The mask includes this capture's own slot, so the frame completes on the
  // capture that fills the last slot.
  assign mask_set = mask_q | (4'b0001 << sel_idx);

  always_comb begin
    prev_an_d      = an_in;
    prev_seg_d     = seg_in;
    shadow_d       = shadow_q;
    shadow_blank_d = shadow_blank_q;
    mask_d         = mask_q;
    digits_d       = digits_q;
    blank_d        = blank_q;
    fv_d           = 1'b0;
    err_d          = err_q;

    if (capture) begin
      mask_d = mask_set;
      if (glyph_hit) begin
        shadow_d[{sel_idx, 2'b00} +: 4] = glyph_val;
        shadow_blank_d[sel_idx]         = 1'b0;
      end else if (glyph_blank) begin
        // A dark digit keeps its last nibble; only the blank flag changes.
        shadow_blank_d[sel_idx] = 1'b1;
      end else begin
        err_d = 1'b1;
      end

      if (mask_set == 4'b1111) begin
        digits_d = shadow_d;
        blank_d  = shadow_blank_d;
        fv_d     = 1'b1;
        mask_d   = 4'b0000;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_an_q      <= 4'b0000;
      prev_seg_q     <= 7'b0000000;
      cnt_q          <= '0;
      shadow_q       <= 16'h0000;
      shadow_blank_q <= 4'b0000;
      mask_q         <= 4'b0000;
      digits_q       <= 16'h0000;
      blank_q        <= 4'b0000;
      fv_q           <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      prev_an_q      <= prev_an_d;
      prev_seg_q     <= prev_seg_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      shadow_blank_q <= shadow_blank_d;
      mask_q         <= mask_d;
      digits_q       <= digits_d;
      blank_q        <= blank_d;
      fv_q           <= fv_d;
      err_q          <= err_d;
    end
  end

  assign digits      = digits_q;
  assign blank_mask  = blank_q;
  assign frame_valid = fv_q;
  assign glyph_error = err_q;

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Testbench for segment_scan_decoder: directed scenarios followed by random scanning.
// All outputs are compared every cycle against a dwell-length reference model.
module tb_segment_scan_decoder;

  localparam int SETTLE = 4;

  logic        clock;
  logic        reset;
  logic [3:0]  an_in;
  logic [6:0]  seg_in;
  logic [15:0] digits;
  logic [3:0]  blank_mask;
  logic        frame_valid;
  logic        glyph_error;

  segment_scan_decoder #(.SETTLE(SETTLE), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .an_in       (an_in),
    .seg_in      (seg_in),
    .digits      (digits),
    .blank_mask  (blank_mask),
    .frame_valid (frame_valid),
    .glyph_error (glyph_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [6:0] S_0 = 7'b1000000, S_1 = 7'b1111001, S_2 = 7'b0100100,
                         S_3 = 7'b0110000, S_5 = 7'b0010010, S_7 = 7'b1111000,
                         S_8 = 7'b0000000, S_9 = 7'b0010000, S_A = 7'b0001000,
                         S_BLANK = 7'b1111111, S_BAD = 7'b0111111;

  logic [6:0] glyph_tab [16];

  int checks   = 0;
  int failures = 0;
  int fcount   = 0;

  // Reference model state
  logic [3:0]  m_last_an;
  logic [6:0]  m_last_seg;
  int          m_hold;
  logic [3:0]  m_val [4];
  logic        m_blank [4];
  logic        m_seen [4];
  logic [15:0] e_digits;
  logic [3:0]  e_blank;
  logic        e_fv;
  logic        e_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int low_count(input logic [3:0] a);
    int n = 0;
    for (int i = 0; i < 4; i++) if (a[i] == 1'b0) n++;
    return n;
  endfunction

  // Model one rising edge. A digit is captured once its anode/segment values
  // have been seen unchanged for SETTLE successive edges after the edge on which
  // they first appeared. A frame publishes when every slot has been captured.
  task automatic model_edge(input logic [3:0] an, input logic [6:0] seg, input logic rst);
    e_fv = 1'b0;
    if (rst) begin
      m_last_an = '0; m_last_seg = '0; m_hold = 0;
      for (int i = 0; i < 4; i++) begin
        m_val[i] = 4'h0; m_blank[i] = 1'b0; m_seen[i] = 1'b0;
      end
      e_digits = 16'h0000; e_blank = 4'h0; e_err = 1'b0;
      return;
    end
    if (low_count(an) == 1 && an == m_last_an && seg == m_last_seg) m_hold++;
    else m_hold = 0;
    if (m_hold == SETTLE) begin
      int k = 0;
      int v = -1;
      for (int i = 0; i < 4; i++) if (an[i] == 1'b0) k = i;
      for (int g = 0; g < 16; g++) if (glyph_tab[g] == seg) v = g;
      if (v >= 0) begin
        m_val[k] = 4'(v); m_blank[k] = 1'b0;
      end else if (seg == S_BLANK) begin
        m_blank[k] = 1'b1;
      end else begin
        e_err = 1'b1;
      end
      m_seen[k] = 1'b1;
      if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
        for (int i = 0; i < 4; i++) begin
          e_digits[4*i +: 4] = m_val[i];
          e_blank[i]         = m_blank[i];
          m_seen[i]          = 1'b0;
        end
        e_fv = 1'b1;
      end
    end
    m_last_an  = an;
    m_last_seg = seg;
  endtask

  task automatic cyc(input logic [3:0] an, input logic [6:0] seg, input logic rst);
    an_in = an; seg_in = seg; reset = rst;
    @(posedge clock);
    model_edge(an, seg, rst);
    #1;
    check("digits", 32'(digits), 32'(e_digits));
    check("blank_mask", 32'(blank_mask), 32'(e_blank));
    check("frame_valid", 32'(frame_valid), 32'(e_fv));
    check("glyph_error", 32'(glyph_error), 32'(e_err));
    if (frame_valid === 1'b1) fcount++;
  endtask

  task automatic dwell(input int k, input logic [6:0] seg, input int n);
    logic [3:0] an;
    an = 4'b1111;
    an[k] = 1'b0;
    for (int i = 0; i < n; i++) cyc(an, seg, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'b1111, S_BLANK, 1'b0);
  endtask

  initial begin
    int f0;
    glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    an_in = 4'b1111; seg_in = S_BLANK; reset = 1'b1;

    // Reset held while a valid scan is on the bus
    for (int i = 0; i < 3; i++) cyc(4'b1110, S_1, 1'b1);
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_fv", 32'(frame_valid), 32'h0);

    // Basic frame "1A70", scanned 3..0
    f0 = fcount;
    dwell(3, S_1, 10); dwell(2, S_A, 10); dwell(1, S_7, 10);
    check("basic_no_early_frame", 32'(fcount - f0), 32'd0);
    dwell(0, S_0, 10);
    check("basic_frame_count", 32'(fcount - f0), 32'd1);
    check("basic_digits", 32'(digits), 32'h1A70);
    check("basic_blank", 32'(blank_mask), 32'h0);
    check("basic_err", 32'(glyph_error), 32'h0);

    // Settle filter: a short dwell on digit 2 does not count
    f0 = fcount;
    dwell(2, S_5, SETTLE - 1); idle(2);
    dwell(3, S_3, 8); dwell(1, S_2, 8); dwell(0, S_9, 8);
    check("settle_no_frame", 32'(fcount - f0), 32'd0);
    dwell(2, S_8, 8);
    check("settle_frame", 32'(fcount - f0), 32'd1);
    check("settle_digits", 32'(digits), 32'h3829);

    // Overlapping anodes are ignored; a mid-dwell segment change restarts settle
    f0 = fcount;
    for (int i = 0; i < 20; i++) cyc(4'b0011, S_1, 1'b0);
    idle(3);
    dwell(2, S_1, 8); dwell(1, S_1, 8); dwell(0, S_5, 3);
    check("glitch_no_frame", 32'(fcount - f0), 32'd0);
    check("glitch_no_err", 32'(glyph_error), 32'h0);
    dwell(0, S_8, 10);
    check("glitch_still_no_frame", 32'(fcount - f0), 32'd0);
    dwell(3, S_7, 8);
    check("restart_frame", 32'(fcount - f0), 32'd1);
    check("restart_digits", 32'(digits), 32'h7118);

    // Blank digit 1
    dwell(3, S_2, 8); dwell(2, S_5, 8); dwell(1, S_BLANK, 8); dwell(0, S_9, 8);
    check("blank_mask_d1", 32'(blank_mask), 32'h2);
    check("blank_digits", 32'(digits), 32'h2519);

    // Bad pattern on digit 3 keeps its nibble and sets the sticky error
    dwell(3, S_BAD, 8); dwell(2, S_1, 8); dwell(1, S_3, 8); dwell(0, S_8, 8);
    check("err_set", 32'(glyph_error), 32'h1);
    check("err_keeps_nibble", 32'(digits[15:12]), 32'h2);
    dwell(3, S_0, 8); dwell(2, S_0, 8); dwell(1, S_0, 8); dwell(0, S_0, 8);
    check("err_sticky", 32'(glyph_error), 32'h1);

    // Reset mid-frame discards the partial capture
    f0 = fcount;
    dwell(3, S_1, 8); dwell(2, S_2, 8); dwell(1, S_3, 8);
    cyc(4'b1110, S_5, 1'b1);
    dwell(0, S_5, 8);
    check("midreset_no_frame", 32'(fcount - f0), 32'd0);
    check("midreset_err_clear", 32'(glyph_error), 32'h0);
    dwell(3, S_9, 8); dwell(2, S_A, 8); dwell(1, S_7, 8); dwell(0, S_5, 8);
    check("midreset_frame", 32'(fcount - f0), 32'd1);
    check("midreset_digits", 32'(digits), 32'h9A75);

    // Random scanning against the model
    for (int d = 0; d < 400; d++) begin
      logic [3:0] an;
      logic [6:0] seg;
      int r;
      int len;
      r   = int'($urandom_range(0, 9));
      seg = (r < 7 || r == 9) ? glyph_tab[$urandom_range(0, 15)]
          : (r == 7) ? S_BLANK : 7'($urandom);
      r   = int'($urandom_range(0, 9));
      an  = 4'b1111;
      if (r < 8) an[$urandom_range(0, 3)] = 1'b0;
      else if (r == 8) an = 4'($urandom);
      len = int'($urandom_range(1, 9));
      if ($urandom_range(0, 49) == 0) cyc(an, seg, 1'b1);
      for (int i = 0; i < len; i++) cyc(an, seg, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
